bcd_alu_seq: RTL
================

Name: bcd_alu_seq

Overview:
Sequential, digit-parametrised successor to the combinational calculator core. Takes two packed BCD operands and a 3-bit op code, runs a start/busy/done handshake, and returns a packed BCD result with overflow, negative and error flags.
ADD/SUB run digit-serially in BCD, one digit per cycle. AND/OR/XOR convert both operands to binary, apply the op, then convert back with double-dabble. Sits between the keypad/operand registers and the display driver, gated by the calculator's "compute" state via en.

Parameters:
DIGITS, 4, number of BCD digits per operand and result (1..8)
BIN_W, 14, binary width for logic ops; must satisfy 2^BIN_W >= 10^DIGITS

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  compute enable; low aborts and clears
start  in  1  one-cycle request, sampled only in IDLE with en=1
op  in  3  0=ADD 1=SUB 2=XOR 3=AND 4=OR, 5..7 invalid
a_bcd  in  4*DIGITS  operand A, digit 0 in bits [3:0]
b_bcd  in  4*DIGITS  operand B, same packing
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse, result valid
result  out  4*DIGITS  packed BCD result, held until next accepted start
ovf  out  1  carry out of ADD, or logic result >= 10^DIGITS
neg  out  1  SUB with A<B; result holds |A-B|
err  out  1  invalid op or any operand nibble > 9

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, ovf, neg, err = 0; result = 0. Release is synchronous to clk.
- Accept rule: start is accepted only when state=IDLE and en=1. On the accepting edge, a_bcd, b_bcd and op are captured; later input changes are ignored.
- start while busy or in DONE is ignored; no queuing.
- States:
  - IDLE
  - ADDSUB: DIGITS cycles, LSD first, carry/borrow register
  - COMP: DIGITS cycles, ten's complement of the SUB result
  - TOBIN: DIGITS cycles, both operands in parallel, acc = acc*10 + digit, MSD first
  - LOGIC: 1 cycle
  - TOBCD: BIN_W cycles, double-dabble into DIGITS+1 digits
  - DONE: 1 cycle, done=1
- Transitions:
  - Accepted start with invalid op or bad nibble: go to DONE with err=1, result=0, ovf=neg=0.
  - ADD: ADDSUB -> DONE. ovf = final carry; result = low DIGITS digits.
  - SUB: ADDSUB -> DONE if final borrow=0; otherwise ADDSUB -> COMP -> DONE with neg=1.
  - XOR/AND/OR: TOBIN -> LOGIC -> TOBCD -> DONE. ovf = (extra top digit != 0); result = low DIGITS digits.
- Latency, counted from the accepting edge to the edge that raises done:
  - invalid: 1
  - ADD, or SUB without borrow: DIGITS+1
  - SUB with borrow: 2*DIGITS+1
  - logic: DIGITS+BIN_W+2
- busy = 1 in every state except IDLE and DONE.
- Flags: ovf, neg and err are cleared on an accepted start and updated together with result in DONE. All are held until the next accepted start.
- Abort (en=0 in any state): on the next edge go to IDLE; result, flags, busy and done all clear to 0. While en=0, outputs stay 0.
- Zero results: 0-0 gives result=0, neg=0. A-B with A==B gives neg=0.

Test Plan:
- DIGITS=4. ADD a=1234, b=5678 -> done 5 cycles after start, result=6912, ovf=0. Then ADD 9999+0001 -> result=0000, ovf=1.
- SUB a=0100, b=0250 -> done after 9 cycles, result=0150, neg=1. SUB 0250-0100 -> result=0150, neg=0, 5 cycles.
- XOR a=1234, b=5678 -> done after 20 cycles, result=4860, ovf=0. OR a=9999, b=6000 -> result=4207, ovf=1.
- Error cases: a_bcd digit0=4'hA with op=ADD -> done next cycle, err=1, result=0. op=6 -> same.
- Handshake: start pulsed again mid-ADD -> ignored, single done pulse. Back-to-back start on the cycle after done -> accepted, flags cleared.
- Abort and reset: en dropped at cycle 3 of an XOR -> IDLE next edge, all outputs 0, no done. rst_n low mid-SUB -> immediate clear; a new op after release completes normally.

Source files
------------

// File: rtl/bcd_alu_if.sv
// Operand/result bundle between the calculator control and the sequential BCD ALU.
// The master drives the request side; the slave returns status and the packed BCD result.
interface bcd_alu_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  start;
    logic [2:0]            op;
    logic [4*DIGITS-1:0]   a_bcd;
    logic [4*DIGITS-1:0]   b_bcd;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   result;
    logic                  ovf;
    logic                  neg;
    logic                  err;

    modport master (
        output en, start, op, a_bcd, b_bcd,
        input  busy, done, result, ovf, neg, err
    );

    modport slave (
        input  en, start, op, a_bcd, b_bcd,
        output busy, done, result, ovf, neg, err
    );
endinterface

// File: rtl/bcd_alu_seq.sv
// Sequential BCD ALU: digit-serial ADD/SUB, and logic ops via BCD->binary,
// binary op, then double-dabble back to BCD. Start/busy/done handshake.
module bcd_alu_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic       clk,
    input  logic       rst_n,
    bcd_alu_if.slave   bus
);
    localparam int DW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDSUB = 3'd1;
    localparam logic [2:0] S_COMP   = 3'd2;
    localparam logic [2:0] S_TOBIN  = 3'd3;
    localparam logic [2:0] S_LOGIC  = 3'd4;
    localparam logic [2:0] S_TOBCD  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;

    localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] BIN_LAST = CNT_W'(BIN_W - 1);

    // Returns {carry_out, sum_digit} for one BCD digit position.
    function automatic logic [4:0] bcd_add_digit(input logic [3:0] x, input logic [3:0] y,
                                                 input logic cin);
        logic [4:0] s;
        s = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
        if (s > 5'd9) begin
            bcd_add_digit = {1'b1, 4'(s - 5'd10)};
        end else begin
            bcd_add_digit = {1'b0, s[3:0]};
        end
    endfunction

    // Returns {borrow_out, diff_digit} for one BCD digit position.
    function automatic logic [4:0] bcd_sub_digit(input logic [3:0] x, input logic [3:0] y,
                                                 input logic bin);
        logic [4:0] sub;
        sub = {1'b0, y} + {4'b0000, bin};
        if ({1'b0, x} < sub) begin
            bcd_sub_digit = {1'b1, 4'({1'b0, x} + 5'd10 - sub)};
        end else begin
            bcd_sub_digit = {1'b0, 4'({1'b0, x} - sub)};
        end
    endfunction

    // True when every nibble of the packed operand is a legal decimal digit.
    function automatic logic bcd_valid(input logic [DW-1:0] v);
        bcd_valid = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bcd_valid = 1'b0;
            end else begin
                bcd_valid = bcd_valid;
            end
        end
    endfunction

    logic [2:0]        state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [2:0]        op_q,     op_d;
    logic [DW-1:0]     a_q,      a_d;
    logic [DW-1:0]     b_q,      b_d;
    logic [BIN_W-1:0]  acc_a_q,  acc_a_d;
    logic [BIN_W-1:0]  acc_b_q,  acc_b_d;
    logic [DW+3:0]     bcd_q,    bcd_d;
    logic              carry_q,  carry_d;
    logic [DW-1:0]     res_q,    res_d;
    logic              wovf_q,   wovf_d;
    logic              wneg_q,   wneg_d;
    logic              werr_q,   werr_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic [DW-1:0]     result_q, result_d;
    logic              ovf_q,    ovf_d;
    logic              neg_q,    neg_d;
    logic              err_q,    err_d;

    logic [4:0]        dig_s;
    logic [DW+3:0]     adj_s;

    // Next-state and datapath logic for every FSM state, with en acting as an abort.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_a_d  = acc_a_q;
        acc_b_d  = acc_b_q;
        bcd_d    = bcd_q;
        carry_d  = carry_q;
        res_d    = res_q;
        wovf_d   = wovf_q;
        wneg_d   = wneg_q;
        werr_d   = werr_q;
        done_d   = 1'b0;
        result_d = result_q;
        ovf_d    = ovf_q;
        neg_d    = neg_q;
        err_d    = err_q;
        busy_d   = 1'b0;
        dig_s    = 5'd0;
        adj_s    = bcd_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    a_d     = bus.a_bcd;
                    b_d     = bus.b_bcd;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    acc_a_d = '0;
                    acc_b_d = '0;
                    bcd_d   = '0;
                    wovf_d  = 1'b0;
                    wneg_d  = 1'b0;
                    werr_d  = 1'b0;
                    ovf_d   = 1'b0;
                    neg_d   = 1'b0;
                    err_d   = 1'b0;
                    if ((bus.op > OP_OR) || !bcd_valid(bus.a_bcd) || !bcd_valid(bus.b_bcd)) begin
                        werr_d  = 1'b1;
                        res_d   = '0;
                        state_d = S_DONE;
                    end else if (bus.op <= OP_SUB) begin
                        state_d = S_ADDSUB;
                    end else begin
                        state_d = S_TOBIN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADDSUB: begin
                if (op_q == OP_ADD) begin
                    dig_s = bcd_add_digit(a_q[3:0], b_q[3:0], carry_q);
                end else begin
                    dig_s = bcd_sub_digit(a_q[3:0], b_q[3:0], carry_q);
                end
                res_d              = res_q >> 4;
                res_d[DW-1 -: 4]   = dig_s[3:0];
                a_d                = a_q >> 4;
                b_d                = b_q >> 4;
                carry_d            = dig_s[4];
                if (cnt_q == DIG_LAST) begin
                    cnt_d = '0;
                    if (op_q == OP_ADD) begin
                        wovf_d  = dig_s[4];
                        state_d = S_DONE;
                    end else if (dig_s[4]) begin
                        carry_d = 1'b0;
                        state_d = S_COMP;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_COMP: begin
                // Ten's complement of the wrapped difference gives |A-B|.
                dig_s            = bcd_sub_digit(4'd0, res_q[3:0], carry_q);
                res_d            = res_q >> 4;
                res_d[DW-1 -: 4] = dig_s[3:0];
                carry_d          = dig_s[4];
                if (cnt_q == DIG_LAST) begin
                    cnt_d   = '0;
                    wneg_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_TOBIN: begin
                acc_a_d = (acc_a_q << 3) + (acc_a_q << 1) + BIN_W'(a_q[DW-1 -: 4]);
                acc_b_d = (acc_b_q << 3) + (acc_b_q << 1) + BIN_W'(b_q[DW-1 -: 4]);
                a_d     = a_q << 4;
                b_d     = b_q << 4;
                if (cnt_q == DIG_LAST) begin
                    cnt_d   = '0;
                    state_d = S_LOGIC;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LOGIC: begin
                case (op_q)
                    OP_XOR:  acc_a_d = acc_a_q ^ acc_b_q;
                    OP_AND:  acc_a_d = acc_a_q & acc_b_q;
                    OP_OR:   acc_a_d = acc_a_q | acc_b_q;
                    default: acc_a_d = acc_a_q;
                endcase
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = S_TOBCD;
            end
            S_TOBCD: begin
                for (int i = 0; i <= DIGITS; i++) begin
                    if (bcd_q[4*i +: 4] >= 4'd5) begin
                        adj_s[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
                    end else begin
                        adj_s[4*i +: 4] = bcd_q[4*i +: 4];
                    end
                end
                bcd_d   = {adj_s[DW+2:0], acc_a_q[BIN_W-1]};
                acc_a_d = acc_a_q << 1;
                if (cnt_q == BIN_LAST) begin
                    cnt_d   = '0;
                    res_d   = bcd_d[DW-1:0];
                    wovf_d  = (bcd_d[DW+3:DW] != 4'd0);
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                done_d   = 1'b1;
                result_d = res_q;
                ovf_d    = wovf_q;
                neg_d    = wneg_q;
                err_d    = werr_q;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (!bus.en) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            done_d   = 1'b0;
            result_d = '0;
            ovf_d    = 1'b0;
            neg_d    = 1'b0;
            err_d    = 1'b0;
            busy_d   = 1'b0;
        end else begin
            busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= 3'd0;
            a_q      <= '0;
            b_q      <= '0;
            acc_a_q  <= '0;
            acc_b_q  <= '0;
            bcd_q    <= '0;
            carry_q  <= 1'b0;
            res_q    <= '0;
            wovf_q   <= 1'b0;
            wneg_q   <= 1'b0;
            werr_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_a_q  <= acc_a_d;
            acc_b_q  <= acc_b_d;
            bcd_q    <= bcd_d;
            carry_q  <= carry_d;
            res_q    <= res_d;
            wovf_q   <= wovf_d;
            wneg_q   <= wneg_d;
            werr_q   <= werr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            neg_q    <= neg_d;
            err_q    <= err_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.ovf    = ovf_q;
    assign bus.neg    = neg_q;
    assign bus.err    = err_q;
endmodule
